// File: rtl/s_mem_pkg.sv
// rtl/s_mem_pkg.sv - shared types and constants for the S-memory phase sequencer
package s_mem_pkg;

    localparam int S_MEM_DEPTH = 256;
    localparam int ADDR_W      = 8;
    localparam int DATA_W      = 8;

    typedef enum logic [1:0] {
        PH_NONE = 2'd0,
        PH_INIT = 2'd1,
        PH_KSA  = 2'd2,
        PH_PRGA = 2'd3
    } phase_t;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_INIT_GO  = 4'd1,
        ST_INIT_RUN = 4'd2,
        ST_KSA_GO   = 4'd3,
        ST_KSA_RUN  = 4'd4,
        ST_PRGA_GO  = 4'd5,
        ST_PRGA_RUN = 4'd6,
        ST_GAP      = 4'd7,
        ST_DONE     = 4'd8
    } state_t;

    // Grant owner for a state; the grant spans both the GO and RUN cycles.
    function automatic phase_t state_phase(input state_t st);
        case (st)
            ST_INIT_GO, ST_INIT_RUN: return PH_INIT;
            ST_KSA_GO,  ST_KSA_RUN:  return PH_KSA;
            ST_PRGA_GO, ST_PRGA_RUN: return PH_PRGA;
            default:                 return PH_NONE;
        endcase
    endfunction

endpackage

// File: rtl/s_mem_port_mux.sv
// rtl/s_mem_port_mux.sv - phase-selected 3:1 S-memory port mux; grant check under S_MEM_GRANT_CHECK_EN
module s_mem_port_mux
    import s_mem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  phase_t              phase,
    input  logic                kill,
    input  logic [ADDR_W-1:0]   init_addr,
    input  logic [DATA_W-1:0]   init_data,
    input  logic                init_wren,
    input  logic [ADDR_W-1:0]   ksa_addr,
    input  logic [DATA_W-1:0]   ksa_data,
    input  logic                ksa_wren,
    input  logic [ADDR_W-1:0]   prga_addr,
    input  logic [DATA_W-1:0]   prga_data,
    input  logic                prga_wren,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_data,
    output logic                mem_wren
`ifdef S_MEM_GRANT_CHECK_EN
    ,
    output logic                violation
`endif
);

    always_comb begin
        mem_addr = '0;
        mem_data = '0;
        mem_wren = 1'b0;
        case (phase)
            PH_INIT: begin
                mem_addr = init_addr;
                mem_data = init_data;
                mem_wren = init_wren;
            end
            PH_KSA: begin
                mem_addr = ksa_addr;
                mem_data = ksa_data;
                mem_wren = ksa_wren;
            end
            PH_PRGA: begin
                mem_addr = prga_addr;
                mem_data = prga_data;
                mem_wren = prga_wren;
            end
            default: ;
        endcase
        // Abort and reset must stop writes in the same cycle, not a cycle later.
        if (kill) mem_wren = 1'b0;
    end

`ifdef S_MEM_GRANT_CHECK_EN
    always_comb begin
        violation = (init_wren && phase != PH_INIT) ||
                    (ksa_wren  && phase != PH_KSA)  ||
                    (prga_wren && phase != PH_PRGA);
    end
`endif

endmodule

// File: rtl/s_mem_phase_sequencer.sv
// rtl/s_mem_phase_sequencer.sv - init/KSA/PRGA sequencer owning the S-memory port; optional S_MEM_GRANT_CHECK_EN
module s_mem_phase_sequencer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic [1:0]          phase,
    output logic                init_start,
    output logic                ksa_start,
    output logic                prga_start,
    input  logic                init_done,
    input  logic                ksa_done,
    input  logic                prga_done,
    input  logic [ADDR_W-1:0]   init_addr,
    input  logic [ADDR_W-1:0]   ksa_addr,
    input  logic [ADDR_W-1:0]   prga_addr,
    input  logic [DATA_W-1:0]   init_data,
    input  logic [DATA_W-1:0]   ksa_data,
    input  logic [DATA_W-1:0]   prga_data,
    input  logic                init_wren,
    input  logic                ksa_wren,
    input  logic                prga_wren,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_data,
    output logic                mem_wren
`ifdef S_MEM_GRANT_CHECK_EN
    ,
    output logic                grant_violation
`endif
);
    import s_mem_pkg::*;

    state_t state, state_nxt;
    phase_t gap_next, gap_next_nxt;
    phase_t phase_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            gap_next <= PH_KSA;
        end else begin
            state    <= state_nxt;
            gap_next <= gap_next_nxt;
        end
    end

    // GAP is shared by both engine hand-overs; gap_next remembers which engine follows.
    always_comb begin
        state_nxt    = state;
        gap_next_nxt = gap_next;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: if (start) state_nxt = ST_INIT_GO;
                ST_INIT_GO:       state_nxt = ST_INIT_RUN;
                ST_INIT_RUN: if (init_done) begin
                    state_nxt    = ST_GAP;
                    gap_next_nxt = PH_KSA;
                end
                ST_KSA_GO:        state_nxt = ST_KSA_RUN;
                ST_KSA_RUN: if (ksa_done) begin
                    state_nxt    = ST_GAP;
                    gap_next_nxt = PH_PRGA;
                end
                ST_PRGA_GO:       state_nxt = ST_PRGA_RUN;
                ST_PRGA_RUN: if (prga_done) state_nxt = ST_DONE;
                ST_GAP:           state_nxt = (gap_next == PH_PRGA) ? ST_PRGA_GO : ST_KSA_GO;
                default:          state_nxt = ST_IDLE;
            endcase
        end
    end

    // Status and start pulses are registered copies of the next-state decode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            phase_q    <= PH_NONE;
            init_start <= 1'b0;
            ksa_start  <= 1'b0;
            prga_start <= 1'b0;
        end else begin
            busy       <= !(state_nxt == ST_IDLE || state_nxt == ST_DONE);
            done       <= (state_nxt == ST_DONE);
            phase_q    <= state_phase(state_nxt);
            init_start <= (state_nxt == ST_INIT_GO);
            ksa_start  <= (state_nxt == ST_KSA_GO);
            prga_start <= (state_nxt == ST_PRGA_GO);
        end
    end

    assign phase = phase_q;

`ifdef S_MEM_GRANT_CHECK_EN
    logic violation;
    logic start_ok;

    assign start_ok = start && !abort && (state == ST_IDLE || state == ST_DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_violation <= 1'b0;
        end else if (start_ok) begin
            grant_violation <= 1'b0;
        end else if (violation) begin
            grant_violation <= 1'b1;
        end
    end
`endif

    s_mem_port_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_port_mux (
        .phase     (phase_q),
        .kill      (abort | ~reset_n),
        .init_addr (init_addr),
        .init_data (init_data),
        .init_wren (init_wren),
        .ksa_addr  (ksa_addr),
        .ksa_data  (ksa_data),
        .ksa_wren  (ksa_wren),
        .prga_addr (prga_addr),
        .prga_data (prga_data),
        .prga_wren (prga_wren),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_wren  (mem_wren)
`ifdef S_MEM_GRANT_CHECK_EN
        ,
        .violation (violation)
`endif
    );

endmodule

// File: tb/tb_s_mem_phase_sequencer.sv
// tb/tb_s_mem_phase_sequencer.sv - self-checking bench for s_mem_phase_sequencer
module tb_s_mem_phase_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0, abort = 1'b0;
    logic       busy, done;
    logic [1:0] phase;
    logic       init_start, ksa_start, prga_start;
    logic       init_done = 1'b0, ksa_done = 1'b0, prga_done = 1'b0;
    logic [7:0] init_addr = '0, ksa_addr = '0, prga_addr = '0;
    logic [7:0] init_data = '0, ksa_data = '0, prga_data = '0;
    logic       init_wren = 1'b0, ksa_wren = 1'b0, prga_wren = 1'b0;
    logic [7:0] mem_addr, mem_data;
    logic       mem_wren;
`ifdef S_MEM_GRANT_CHECK_EN
    logic       grant_violation;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    s_mem_phase_sequencer #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .phase(phase),
        .init_start(init_start), .ksa_start(ksa_start), .prga_start(prga_start),
        .init_done(init_done), .ksa_done(ksa_done), .prga_done(prga_done),
        .init_addr(init_addr), .ksa_addr(ksa_addr), .prga_addr(prga_addr),
        .init_data(init_data), .ksa_data(ksa_data), .prga_data(prga_data),
        .init_wren(init_wren), .ksa_wren(ksa_wren), .prga_wren(prga_wren),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren)
`ifdef S_MEM_GRANT_CHECK_EN
        , .grant_violation(grant_violation)
`endif
    );

    typedef struct {
        int         ph;
        logic [7:0] ia, id, ka, kd, pa, pd;
        logic       iw, kw, pw, ab;
        logic [7:0] ea, ed;
        logic       ew;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {busy, done, phase, init_start, ksa_start, prga_start, mem_wren};
    endfunction

    task automatic clear_in();
        start = 0; abort = 0;
        init_done = 0; ksa_done = 0; prga_done = 0;
        init_wren = 0; ksa_wren = 0; prga_wren = 0;
        init_addr = 0; ksa_addr = 0; prga_addr = 0;
        init_data = 0; ksa_data = 0; prga_data = 0;
    endtask

    // Leaves the DUT in the GO cycle of engine p (p=0: idle).
    task automatic goto_phase(input int p);
        bit ok;
        int pp;
        ok = 0;
        pp = p;
        clear_in();
        abort = 1;
        @(negedge clk);
        abort = 0;
        if (pp != 0) begin
            start = 1;
            @(negedge clk);
            start = 0;
            init_done = (pp > 1);
            ksa_done  = (pp > 2);
            for (int i = 0; i < 40 && !ok; i++) begin
                if (phase == pp[1:0]) ok = 1;
                else @(negedge clk);
            end
            if (!ok) begin
                total++; bad++;
                $display("FAIL goto_phase: got phase %0d want %0d", phase, pp);
            end
            init_done = 0;
            ksa_done = 0;
        end
    endtask

    // Reference model state: run active, engine number 1..3, step 0=go 1=run 2=gap, finished.
    bit       m_act, m_fin;
    int       m_eng, m_sub;

    function automatic logic [7:0] pick8(input int e, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        return (e == 1) ? a : (e == 2) ? b : (e == 3) ? c : 8'h00;
    endfunction

    initial begin
        int lat;
        int ph;
        bit ok;
        logic [7:0] exp;
        logic [2:0] dn, wr;

        tbl[0] = '{1, 8'h2A, 8'h2A, 8'h55, 8'h11, 8'h77, 8'h22, 1, 1, 0, 0, 8'h2A, 8'h2A, 1};
        tbl[1] = '{1, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 0, 0, 1, 0, 8'h10, 8'h20, 0};
        tbl[2] = '{2, 8'h01, 8'h02, 8'h55, 8'hAA, 8'h03, 8'h04, 1, 1, 0, 0, 8'h55, 8'hAA, 1};
        tbl[3] = '{2, 8'h01, 8'h02, 8'h66, 8'h99, 8'h03, 8'h04, 0, 1, 0, 1, 8'h66, 8'h99, 0};
        tbl[4] = '{3, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'hC3, 0, 0, 1, 0, 8'hFF, 8'hC3, 1};
        tbl[5] = '{3, 8'h11, 8'h12, 8'h13, 8'h14, 8'h80, 8'h81, 1, 1, 0, 0, 8'h80, 8'h81, 0};
        tbl[6] = '{0, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 1, 1, 1, 0, 8'h00, 8'h00, 0};
        tbl[7] = '{3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5A, 8'hA5, 0, 0, 1, 1, 8'h5A, 8'hA5, 0};

        // Reset values
        clear_in();
        #12;
        chk("reset_outs", outs(), 8'h00);
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        chk("idle_outs", outs(), 8'h00);

        // Full run: engines finish 5, 10 and 3 cycles after their start pulses
        init_wren = 1; ksa_wren = 1; prga_wren = 1;
        start = 1;
        @(negedge clk);
        start = 0;
        for (int c = 1; c <= 26; c++) begin
            init_done = (c == 6);
            ksa_done  = (c == 18);
            prga_done = (c == 23);
            #1;
            ph = (c >= 1 && c <= 6) ? 1 : (c >= 8 && c <= 18) ? 2 : (c >= 20 && c <= 23) ? 3 : 0;
            exp = {(c <= 23) ? 1'b1 : 1'b0, (c >= 24) ? 1'b1 : 1'b0, ph[1:0],
                   (c == 1) ? 1'b1 : 1'b0, (c == 8) ? 1'b1 : 1'b0, (c == 20) ? 1'b1 : 1'b0,
                   (ph != 0) ? 1'b1 : 1'b0};
            if (outs() !== exp) $display("FAIL seq_cycle_%0d: got %0h want %0h", c, outs(), exp);
            total++;
            if (outs() !== exp) bad++;
            @(negedge clk);
        end

        // Restart from DONE, then minimum latency with every engine done immediately
        clear_in();
        start = 1;
        #1;
        chk("done_before_restart", done, 1);
        @(negedge clk);
        start = 0;
        chk("restart_done_low", done, 0);
        chk("restart_init_start", init_start, 1);
        init_done = 1; ksa_done = 1; prga_done = 1;
        lat = 1;
        while (!done && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        chk("min_latency", lat, 9);

        // start and abort together in IDLE
        goto_phase(0);
        start = 1; abort = 1;
        @(negedge clk);
        start = 0; abort = 0;
        chk("start_abort_idle", outs(), 8'h00);
        @(negedge clk);
        chk("start_abort_idle2", outs(), 8'h00);

        // Second start during INIT_RUN is ignored
        clear_in();
        start = 1;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        chk("restart_ignored", {busy, phase, init_start}, {1'b1, 2'd1, 1'b0});
        init_done = 1; ksa_done = 1; prga_done = 1;
        ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            if (done) ok = 1;
            else @(negedge clk);
        end
        chk("restart_ignored_completes", ok, 1);

        // Abort during KSA_RUN with a write in flight
        goto_phase(2);
        @(negedge clk);
        ksa_wren = 1; ksa_addr = 8'h33;
        #1;
        chk("ksa_write_live", mem_wren, 1);
        abort = 1;
        #1;
        chk("abort_kills_wren", mem_wren, 0);
        @(negedge clk);
        abort = 0;
        chk("abort_to_idle", {busy, done, phase}, 4'h0);
        ksa_done = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_ksa_done", outs(), 8'h00);
        end

        // Async reset during PRGA_RUN
        goto_phase(3);
        @(negedge clk);
        prga_wren = 1;
        #1;
        chk("prga_write_live", mem_wren, 1);
        #1;
        reset_n = 0;
        #1;
        chk("async_reset_outs", outs(), 8'h00);
        @(negedge clk);
        reset_n = 1;
        clear_in();

        // Grant mux vectors
        for (int i = 0; i < 8; i++) begin
            goto_phase(tbl[i].ph);
            init_addr = tbl[i].ia; init_data = tbl[i].id; init_wren = tbl[i].iw;
            ksa_addr  = tbl[i].ka; ksa_data  = tbl[i].kd; ksa_wren  = tbl[i].kw;
            prga_addr = tbl[i].pa; prga_data = tbl[i].pd; prga_wren = tbl[i].pw;
            abort = tbl[i].ab;
            #1;
            chk($sformatf("vec%0d_addr", i), mem_addr, tbl[i].ea);
            chk($sformatf("vec%0d_data", i), mem_data, tbl[i].ed);
            chk($sformatf("vec%0d_wren", i), mem_wren, tbl[i].ew);
        end

`ifdef S_MEM_GRANT_CHECK_EN
        goto_phase(1);
        init_wren = 1; ksa_wren = 1;
        @(negedge clk);
        init_wren = 0; ksa_wren = 0;
        chk("gv_set", grant_violation, 1);
        goto_phase(0);
        chk("gv_sticky", grant_violation, 1);
        start = 1;
        @(negedge clk);
        start = 0;
        chk("gv_cleared", grant_violation, 0);
`endif

        // Randomized run against the reference model
        goto_phase(0);
        m_act = 0; m_fin = 0; m_eng = 1; m_sub = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            start = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 60) == 0);
            dn = 3'($urandom_range(0, 7));
            wr = 3'($urandom_range(0, 7));
            init_done = dn[0]; ksa_done = dn[1]; prga_done = dn[2];
            init_wren = wr[0]; ksa_wren = wr[1]; prga_wren = wr[2];
            init_addr = 8'($urandom); ksa_addr = 8'($urandom); prga_addr = 8'($urandom);
            init_data = 8'($urandom); ksa_data = 8'($urandom); prga_data = 8'($urandom);
            #1;
            ph = (m_act && m_sub != 2) ? m_eng : 0;
            exp = {m_act, m_fin && !m_act, ph[1:0],
                   m_act && m_sub == 0 && m_eng == 1,
                   m_act && m_sub == 0 && m_eng == 2,
                   m_act && m_sub == 0 && m_eng == 3,
                   (ph != 0) && !abort && wr[ph - 1]};
            chk("rand_outs", outs(), exp);
            chk("rand_addr", mem_addr, pick8(ph, init_addr, ksa_addr, prga_addr));
            chk("rand_data", mem_data, pick8(ph, init_data, ksa_data, prga_data));
            @(posedge clk);
            if (abort) begin
                m_act = 0; m_fin = 0;
            end else if (!m_act) begin
                if (start) begin m_act = 1; m_fin = 0; m_eng = 1; m_sub = 0; end
            end else if (m_sub == 0) begin
                m_sub = 1;
            end else if (m_sub == 1) begin
                if (dn[m_eng - 1]) begin
                    if (m_eng == 3) begin m_act = 0; m_fin = 1; end
                    else m_sub = 2;
                end
            end else begin
                m_eng = m_eng + 1;
                m_sub = 0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
